// File: rtl/phase_loop_pkg.sv
// -----------------------------------------------------------------------------
// phase_loop_pkg
// Shared types and helpers for the GPSDO phase loop filter.
//   state_t    : loop filter sequencer states
//   sat_signed : clamp a signed value into the signed range of a given width
//   clamp_dac  : clamp a signed value into the unsigned range [0, 2^w-1]
// -----------------------------------------------------------------------------
package phase_loop_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      INTEG = 3'd2,
      SUM   = 3'd3,
      SAT   = 3'd4
   } state_t;

   // Saturate v to [-(2^(w-1)), 2^(w-1)-1]. Inputs up to 64 bits wide.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

   // Clamp a signed value to the DAC code range [0, 2^w-1].
   function automatic logic [63:0] clamp_dac(input logic signed [63:0] v,
                                             input int w);
      logic signed [63:0] hi;
      hi = (64'sd1 <<< w) - 64'sd1;
      if (v < 64'sd0)
         return 64'd0;
      else if (v > hi)
         return $unsigned(hi);
      else
         return $unsigned(v);
   endfunction

endpackage

// File: rtl/phase_lock_detect.sv
// -----------------------------------------------------------------------------
// phase_lock_detect
// Counts consecutive in-window phase errors and raises lock once LOCK_CNT of
// them have been seen in a row. Any out-of-window sample or an explicit clear
// drops both the counter and the lock flag.
// Ports:
//   CLK_SYS   in  system clock
//   CLK_RST   in  synchronous active-high reset
//   err_valid in  one-cycle strobe: err_abs holds a new accepted sample
//   clear     in  force counter and lock to zero (outlier, holdover)
//   err_abs   in  |err| of the sample, 25 bits unsigned
//   lock      out lock flag, registered
// -----------------------------------------------------------------------------
module phase_lock_detect
   import phase_loop_pkg::*;
#(
   parameter int LOCK_WIN = 20,
   parameter int LOCK_CNT = 16
) (
   input  logic        CLK_SYS,
   input  logic        CLK_RST,
   input  logic        err_valid,
   input  logic        clear,
   input  logic [24:0] err_abs,
   output logic        lock
);

   localparam int CW = $clog2(LOCK_CNT + 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          lock_reg;
   logic          lock_next;

   always_comb begin
      cnt_next  = cnt_reg;
      lock_next = lock_reg;
      if (clear) begin
         cnt_next  = '0;
         lock_next = 1'b0;
      end else if (err_valid) begin
         if (err_abs <= 25'(LOCK_WIN)) begin
            // Counter parks at LOCK_CNT so lock stays asserted indefinitely.
            if (cnt_reg != CW'(LOCK_CNT))
               cnt_next = cnt_reg + CW'(1);
            lock_next = (cnt_next == CW'(LOCK_CNT));
         end else begin
            cnt_next  = '0;
            lock_next = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK_SYS) begin
      if (CLK_RST) begin
         cnt_reg  <= '0;
         lock_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         lock_reg <= lock_next;
      end
   end

   assign lock = lock_reg;

endmodule

// File: rtl/phase_loop_filter.sv
// -----------------------------------------------------------------------------
// phase_loop_filter
// GPSDO loop filter: takes the 24-bit GPS-to-local phase count on each
// Measure_Done, forms err = phase - PHASE_SETPOINT, rejects outliers, runs a
// saturating PI filter and drives a clamped OCXO tuning DAC code.
// Sequencer: IDLE -> CALC -> INTEG -> SUM -> SAT -> IDLE. Measure_Done in
// cycle N gives DAC_Valid (and the new DAC_Code) in cycle N+4. Strobes that
// arrive while the sequencer is busy are dropped.
// Optional build macro: PHASE_LOOP_HOLDOVER_EN (GPS-loss holdover detection).
// Ports:
//   CLK_SYS          in  system clock
//   CLK_RST          in  synchronous active-high reset
//   Measure_Phase    in  24-bit phase count, valid with Measure_Done
//   Measure_Done     in  one-cycle sample strobe
//   flag_GPS_posedge in  GPS 1PPS edge strobe (holdover build only)
//   Loop_Enable      in  1 = closed loop, 0 = DAC returns to DAC_CENTER
//   DAC_Code         out registered tuning word
//   DAC_Valid        out one-cycle strobe on DAC_Code update
//   Phase_Err        out signed error of the last sample
//   Lock             out loop locked
//   Reject_Cnt       out saturating count of outlier rejections
//   Holdover         out GPS lost (0 unless PHASE_LOOP_HOLDOVER_EN)
// -----------------------------------------------------------------------------
module phase_loop_filter
   import phase_loop_pkg::*;
#(
   parameter int DAC_W          = 16,
   parameter int DAC_CENTER     = 32768,
   parameter int PHASE_SETPOINT = 100,
   parameter int ACC_W          = 32,
   parameter int KP_SHIFT       = 2,
   parameter int KI_SHIFT       = 6,
   parameter int MAX_ERR        = 10000,
   parameter int LOCK_WIN       = 20,
   parameter int LOCK_CNT       = 16,
   parameter int HOLD_SECS      = 3
) (
   input  logic                    CLK_SYS,
   input  logic                    CLK_RST,
   input  logic [23:0]             Measure_Phase,
   input  logic                    Measure_Done,
   input  logic                    flag_GPS_posedge,
   input  logic                    Loop_Enable,
   output logic [DAC_W-1:0]        DAC_Code,
   output logic                    DAC_Valid,
   output logic signed [24:0]      Phase_Err,
   output logic                    Lock,
   output logic [7:0]              Reject_Cnt,
   output logic                    Holdover
);

   localparam int SW = ACC_W + 2;

   state_t                    state_reg;
   state_t                    state_next;
   logic signed [24:0]        err_reg;
   logic signed [24:0]        phase_err_reg;
   logic signed [ACC_W-1:0]   acc_reg;
   logic [DAC_W-1:0]          dac_code_reg;
   logic                      dac_valid_reg;
   logic [7:0]                reject_cnt_reg;

   logic signed [24:0]        err_sample;
   logic [24:0]               err_abs;
   logic                      is_outlier;
   logic signed [ACC_W:0]     acc_sum;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [SW-1:0]      s_val;
   logic [DAC_W-1:0]          dac_clamped;
   logic                      holdover_gate;
   logic                      holdover_state;
   logic                      lock_sample;
   logic                      lock_clear;

   // ---------------------------------------------------------------- datapath
   assign err_sample = $signed({1'b0, Measure_Phase}) - $signed(25'(PHASE_SETPOINT));
   assign err_abs    = err_reg[24] ? (~err_reg + 25'd1) : err_reg;
   assign is_outlier = (err_abs > 25'(MAX_ERR));

   // One extra bit of headroom so the sum itself cannot wrap before clamping.
   assign acc_sum  = $signed((ACC_W+1)'(acc_reg)) + $signed((ACC_W+1)'(err_reg));
   assign acc_next = ACC_W'(sat_signed(64'(acc_sum), ACC_W));

   always_comb begin
      s_val = SW'(DAC_CENTER);
      if (Loop_Enable)
         s_val = SW'(DAC_CENTER) + (SW'(err_reg) >>> KP_SHIFT)
                                 + (SW'(acc_reg) >>> KI_SHIFT);
   end

   assign dac_clamped = DAC_W'(clamp_dac(64'(s_val), DAC_W));

   // ---------------------------------------------------------------- sequencer
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (Measure_Done && !holdover_gate) state_next = CALC;
         CALC:    state_next = is_outlier ? IDLE : INTEG;
         INTEG:   state_next = SUM;
         SUM:     state_next = SAT;
         SAT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_SYS) begin
      if (CLK_RST) begin
         state_reg      <= IDLE;
         err_reg        <= '0;
         phase_err_reg  <= '0;
         acc_reg        <= '0;
         dac_code_reg   <= DAC_W'(DAC_CENTER);
         dac_valid_reg  <= 1'b0;
         reject_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         dac_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (Measure_Done && !holdover_gate)
                  err_reg <= err_sample;
            end
            CALC: begin
               phase_err_reg <= err_reg;
               if (is_outlier && (reject_cnt_reg != 8'hFF))
                  reject_cnt_reg <= reject_cnt_reg + 8'd1;
            end
            INTEG: begin
               acc_reg <= Loop_Enable ? acc_next : '0;
            end
            SUM: begin
               // Registered here so the update and its strobe are both
               // visible during the SAT cycle.
               dac_code_reg  <= dac_clamped;
               dac_valid_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- holdover
`ifdef PHASE_LOOP_HOLDOVER_EN
   logic [7:0] hold_cnt_reg;
   logic       holdover_reg;
   logic       hold_hit;

   // The pulse that brings the count to HOLD_SECS is itself discarded.
   assign hold_hit = Measure_Done && !flag_GPS_posedge &&
                     (({24'd0, hold_cnt_reg} + 32'd1) >= 32'(HOLD_SECS));

   always_ff @(posedge CLK_SYS) begin
      if (CLK_RST) begin
         hold_cnt_reg <= '0;
         holdover_reg <= 1'b0;
      end else if (flag_GPS_posedge) begin
         hold_cnt_reg <= '0;
         holdover_reg <= 1'b0;
      end else if (Measure_Done) begin
         if (hold_cnt_reg != 8'hFF)
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
         if (hold_hit)
            holdover_reg <= 1'b1;
      end
   end

   assign holdover_gate  = holdover_reg | hold_hit;
   assign holdover_state = holdover_reg;
`else
   logic unused_holdover;
   localparam int unused_hold_secs = HOLD_SECS;
   assign unused_holdover = &{1'b0, flag_GPS_posedge, unused_hold_secs[0]};
   assign holdover_gate   = 1'b0;
   assign holdover_state  = 1'b0;
`endif

   // ---------------------------------------------------------------- lock
   assign lock_sample = (state_reg == CALC) && !is_outlier;
   assign lock_clear  = ((state_reg == CALC) && is_outlier) || holdover_state;

   phase_lock_detect #(
      .LOCK_WIN (LOCK_WIN),
      .LOCK_CNT (LOCK_CNT)
   ) u_lock (
      .CLK_SYS   (CLK_SYS),
      .CLK_RST   (CLK_RST),
      .err_valid (lock_sample),
      .clear     (lock_clear),
      .err_abs   (err_abs),
      .lock      (Lock)
   );

   assign DAC_Code   = dac_code_reg;
   assign DAC_Valid  = dac_valid_reg;
   assign Phase_Err  = phase_err_reg;
   assign Reject_Cnt = reject_cnt_reg;
   assign Holdover   = holdover_state;

endmodule

// File: tb/tb_phase_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_phase_loop_filter
// Directed bench for phase_loop_filter (default build, holdover disabled).
// Expected values are hand computed from the filter equations with the
// default parameters (center 32768, setpoint 100, Kp >>> 2, Ki >>> 6).
// -----------------------------------------------------------------------------
module tb_phase_loop_filter;

   logic               CLK_SYS = 1'b0;
   logic               CLK_RST;
   logic [23:0]        Measure_Phase;
   logic               Measure_Done;
   logic               flag_GPS_posedge;
   logic               Loop_Enable;
   logic [15:0]        DAC_Code;
   logic               DAC_Valid;
   logic signed [24:0] Phase_Err;
   logic               Lock;
   logic [7:0]         Reject_Cnt;
   logic               Holdover;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK_SYS = ~CLK_SYS;

   phase_loop_filter dut (
      .CLK_SYS          (CLK_SYS),
      .CLK_RST          (CLK_RST),
      .Measure_Phase    (Measure_Phase),
      .Measure_Done     (Measure_Done),
      .flag_GPS_posedge (flag_GPS_posedge),
      .Loop_Enable      (Loop_Enable),
      .DAC_Code         (DAC_Code),
      .DAC_Valid        (DAC_Valid),
      .Phase_Err        (Phase_Err),
      .Lock             (Lock),
      .Reject_Cnt       (Reject_Cnt),
      .Holdover         (Holdover)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("%s miscompare", tag);
      end
   endtask

   task automatic step();
      @(posedge CLK_SYS);
      #1;
   endtask

   // Apply one Measure_Done and watch 6 further cycles. valid_at is the cycle
   // index (after the sampling edge) of the first DAC_Valid; 3 means N+4.
   // inj > 0 drives an extra Measure_Done (phase 20000) before edge inj.
   task automatic do_sample(input logic [23:0] ph, input int inj,
                            output int valid_cnt, output int valid_at);
      valid_cnt = 0;
      valid_at  = -1;
      Measure_Phase = ph;
      Measure_Done  = 1'b1;
      step();
      Measure_Done  = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (i == inj) begin
            Measure_Phase = 24'd20000;
            Measure_Done  = 1'b1;
         end
         step();
         Measure_Done = 1'b0;
         if (DAC_Valid) begin
            valid_cnt++;
            if (valid_at < 0) valid_at = i;
         end
      end
   endtask

   initial begin
      int vc, va, tot;
      logic [15:0] prev_dac;
      logic mono;

      CLK_RST          = 1'b1;
      Measure_Phase    = '0;
      Measure_Done     = 1'b0;
      flag_GPS_posedge = 1'b0;
      Loop_Enable      = 1'b0;
      repeat (3) step();
      CLK_RST = 1'b0;
      step();

      // Reset state
      check("rst_dac_code",   32'(DAC_Code), 32'd32768);
      check("rst_dac_valid",  32'(DAC_Valid), 32'd0);
      check("rst_phase_err",  32'(Phase_Err), 32'd0);
      check("rst_lock",       32'(Lock), 32'd0);
      check("rst_reject_cnt", 32'(Reject_Cnt), 32'd0);
      check("rst_holdover",   32'(Holdover), 32'd0);

      // Zero error sample: latency and center code
      Loop_Enable = 1'b1;
      do_sample(24'd100, 0, vc, va);
      check("zero_valid_cnt", 32'(vc), 32'd1);
      check("zero_latency",   32'(va), 32'd3);
      check("zero_dac",       32'(DAC_Code), 32'd32768);
      check("zero_phase_err", 32'(Phase_Err), 32'd0);

      // err = 64: 16 proportional + acc 64>>>6 = 1, then acc 128 -> 2
      do_sample(24'd164, 0, vc, va);
      check("p164a_dac",       32'(DAC_Code), 32'd32785);
      check("p164a_phase_err", 32'(Phase_Err), 32'd64);
      do_sample(24'd164, 0, vc, va);
      check("p164b_dac",       32'(DAC_Code), 32'd32786);

      // Outlier: err = 19900
      do_sample(24'd20000, 0, vc, va);
      check("rej_valid_cnt", 32'(vc), 32'd0);
      check("rej_cnt",       32'(Reject_Cnt), 32'd1);
      check("rej_dac_hold",  32'(DAC_Code), 32'd32786);
      check("rej_phase_err", 32'(Phase_Err), 32'd19900);
      check("rej_lock",      32'(Lock), 32'd0);

      // Lock: 16 in-window samples (err = 10); acc 128 -> 288
      for (int k = 1; k <= 16; k++) begin
         do_sample(24'd110, 0, vc, va);
         if (k == 15) check("lock_after_15", 32'(Lock), 32'd0);
      end
      check("lock_after_16", 32'(Lock), 32'd1);
      check("lock_dac",      32'(DAC_Code), 32'd32774);

      // err = 30 leaves the window: acc 318 -> 32768 + 7 + 4
      do_sample(24'd130, 0, vc, va);
      check("unlock_lock", 32'(Lock), 32'd0);
      check("unlock_dac",  32'(DAC_Code), 32'd32779);

      // Busy: second strobe 2 cycles after the first is ignored; acc 328
      do_sample(24'd110, 2, vc, va);
      check("busy_valid_cnt", 32'(vc), 32'd1);
      check("busy_rej_cnt",   32'(Reject_Cnt), 32'd1);
      check("busy_phase_err", 32'(Phase_Err), 32'd10);
      check("busy_dac",       32'(DAC_Code), 32'd32775);

      // 300 outliers: counter saturates
      tot = 0;
      for (int k = 0; k < 300; k++) begin
         do_sample(24'd20000, 0, vc, va);
         tot += vc;
      end
      check("rej300_valid_total", 32'(tot), 32'd0);
      check("rej300_cnt",         32'(Reject_Cnt), 32'd255);
      check("rej300_dac_hold",    32'(DAC_Code), 32'd32775);

      // 300 samples at err = 9000: DAC climbs and clamps at full scale
      tot      = 0;
      mono     = 1'b1;
      prev_dac = DAC_Code;
      for (int k = 0; k < 300; k++) begin
         do_sample(24'd9100, 0, vc, va);
         tot += vc;
         if (DAC_Code < prev_dac) mono = 1'b0;
         prev_dac = DAC_Code;
      end
      check("hi_valid_total", 32'(tot), 32'd300);
      check("hi_monotonic",   32'(mono), 32'd1);
      check("hi_dac_clamp",   32'(DAC_Code), 32'd65535);

      // Loop disabled: DAC to center, acc cleared
      Loop_Enable = 1'b0;
      do_sample(24'd9100, 0, vc, va);
      check("dis_valid_cnt", 32'(vc), 32'd1);
      check("dis_dac",       32'(DAC_Code), 32'd32768);
      check("dis_phase_err", 32'(Phase_Err), 32'd9000);
      Loop_Enable = 1'b1;
      do_sample(24'd100, 0, vc, va);
      check("reen_zero_dac", 32'(DAC_Code), 32'd32768);
      do_sample(24'd164, 0, vc, va);
      check("reen_p164_dac", 32'(DAC_Code), 32'd32785);

      // Reset in the middle of a computation: no strobe, DAC back to center
      Measure_Phase = 24'd164;
      Measure_Done  = 1'b1;
      step();
      Measure_Done  = 1'b0;
      step();
      CLK_RST = 1'b1;
      tot = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 1) CLK_RST = 1'b0;
         if (DAC_Valid) tot++;
      end
      check("midrst_valid_total", 32'(tot), 32'd0);
      check("midrst_dac",         32'(DAC_Code), 32'd32768);
      check("midrst_rej_cnt",     32'(Reject_Cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/phase_loop_filter.md
Name: phase_loop_filter

Overview:
- Downstream consumer of the 1PPS phase-measurement stage in the GPSDO FPGA.
- Samples the 24-bit GPS-to-local phase count on each measurement-done pulse and subtracts a setpoint to get a signed error.
- Rejects outliers, then runs a saturating PI loop filter and emits a clamped OCXO tuning DAC code with a one-cycle valid strobe.
- Also reports lock status and a count of rejected samples.

Parameters:
- DAC_W, 16, width of the DAC code output.
- DAC_CENTER, 32768, DAC code driven at reset and whenever the loop is disabled.
- PHASE_SETPOINT, 100, target phase count in CLK_SYS cycles.
- ACC_W, 32, integrator width (signed).
- KP_SHIFT, 2, proportional gain. Term is err >>> KP_SHIFT.
- KI_SHIFT, 6, integral gain. Term is acc >>> KI_SHIFT.
- MAX_ERR, 10000, outlier threshold on |err|.
- LOCK_WIN, 20, lock window on |err|.
- LOCK_CNT, 16, number of consecutive in-window samples needed to declare lock.
- HOLD_SECS, 3, holdover timeout in Measure_Done pulses. Used only when the optional feature is enabled.

Ports:
- CLK_SYS  in  1  system clock.
- CLK_RST  in  1  synchronous active-high reset.
- Measure_Phase  in  24  unsigned phase count; valid only in the cycle Measure_Done is high.
- Measure_Done  in  1  one-cycle sample strobe.
- flag_GPS_posedge  in  1  one-cycle GPS 1PPS edge strobe; used only by the holdover feature.
- Loop_Enable  in  1  level; 1 = closed loop, 0 = DAC held at DAC_CENTER.
- DAC_Code  out  DAC_W  registered tuning word.
- DAC_Valid  out  1  one-cycle strobe when DAC_Code has been updated.
- Phase_Err  out  25  signed error of the last sample, registered.
- Lock  out  1  loop locked.
- Reject_Cnt  out  8  count of outlier rejections; saturates at 255.
- Holdover  out  1  GPS lost. Tied 0 without the macro.

Behaviour:
- Reset values: CLK_RST is synchronous and active-high. It forces DAC_Code=DAC_CENTER and clears DAC_Valid, Phase_Err, Lock, Reject_Cnt, Holdover, the integrator, the lock counter and the FSM (to IDLE). Reset mid-operation aborts the computation; no DAC_Valid is produced.
- FSM states: IDLE, CALC, INTEG, SUM, SAT.
- IDLE:
  - On Measure_Done, capture err = {1'b0,Measure_Phase} - PHASE_SETPOINT as a 25-bit signed value.
  - Go to CALC.
- CALC:
  - Register Phase_Err=err.
  - If |err| > MAX_ERR: Reject_Cnt++ (saturating), lock counter and Lock clear, return to IDLE. No DAC_Valid is produced.
  - Otherwise update the lock logic, then go to INTEG.
- Lock logic:
  - |err| <= LOCK_WIN: increment the counter, saturating at LOCK_CNT. Lock=1 when the counter reaches LOCK_CNT.
  - Otherwise: counter and Lock clear.
- INTEG:
  - If Loop_Enable: acc = acc + sign-extended err, saturating to the signed ACC_W range, never wrapping.
  - If not Loop_Enable: acc = 0.
- SUM: s = DAC_CENTER + (err >>> KP_SHIFT) + (acc >>> KI_SHIFT), computed at ACC_W+2 bits signed. Not Loop_Enable forces s = DAC_CENTER.
- SAT:
  - Clamp s to [0, 2^DAC_W-1] and register it to DAC_Code.
  - DAC_Valid=1 for exactly this cycle, then return to IDLE.
- Latency: Measure_Done in cycle N gives DAC_Valid/DAC_Code in cycle N+4.
- Busy handling: a Measure_Done that arrives while the FSM is not in IDLE is ignored; nothing is counted.
- Loop_Enable falling: acc is cleared at the next INTEG, and DAC_Code returns to DAC_CENTER on the next sample, not immediately.
- Between updates, DAC_Code holds its value.

Optional Feature:
- Macro: PHASE_LOOP_HOLDOVER_EN.
- With the macro:
  - A counter counts Measure_Done pulses since the last flag_GPS_posedge; flag_GPS_posedge clears it. If both arrive in the same cycle, the counter clears.
  - When the count reaches HOLD_SECS, Holdover=1.
  - While Holdover=1, samples are taken in IDLE but discarded: no PI update, DAC_Code frozen at its last value, acc frozen, Lock cleared, no DAC_Valid.
  - Holdover clears on the next flag_GPS_posedge.
- Without the macro: Holdover is constant 0 and flag_GPS_posedge is unused.

Decomposition:
- Package phase_loop_pkg:
  - FSM state enum.
  - Signed-saturate function, parameterised by width.
  - DAC clamp function.
- Natural sub-module: phase_lock_detect (lock counter plus Lock flag). Inputs: an err-valid strobe and |err|.

Test Plan:
- Reset then Loop_Enable=1, Measure_Phase=100 with Measure_Done -> DAC_Valid 4 cycles later, DAC_Code=32768, Phase_Err=0.
- Two samples at Measure_Phase=164 -> DAC_Code=32785 (16 proportional + 1 integral), then 32786 (acc=128).
- Measure_Phase=20000 -> no DAC_Valid, Reject_Cnt=1, DAC_Code unchanged, Lock cleared. 300 rejected samples -> Reject_Cnt=255.
- 300 samples at Measure_Phase=9100 -> DAC_Code saturates at 65535 and stays there; acc is monotonic, no wrap. Loop_Enable=0 then one sample -> DAC_Code=32768.
- Lock: 16 samples at Measure_Phase=110 -> Lock rises in CALC of the 16th sample; one sample at 130 -> Lock=0. A second Measure_Done 2 cycles after the first -> ignored, single DAC_Valid.
- PHASE_LOOP_HOLDOVER_EN: 3 Measure_Done pulses with no flag_GPS_posedge -> Holdover=1, DAC_Code frozen, no DAC_Valid. One flag_GPS_posedge -> Holdover=0, the next sample updates normally.
